// File: rtl/ddr_rd_arb.sv
// ddr_rd_arb: round-robin owner of the shared DDR read port.
// Three requesters (Sobel, block matcher, disparity/post) take turns.
// The owner's command words are forwarded to the read master with one
// cycle of latency, and returned data is steered back to the owner only.
// After a release, late return data keeps flowing to the previous owner
// for DRAIN_CYC cycles before the port is offered again. A grant that
// lasts MAX_GRANT cycles is cut off and raises a sticky timeout flag.
module ddr_rd_arb #(
   parameter int DRAIN_CYC = 4,
   parameter int MAX_GRANT = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  drd_req,
   output logic [2:0]  drd_ack,
   input  logic [2:0]  drd_vout,
   input  logic [95:0] drd_dout,
   output logic [2:0]  drd_vin,
   output logic [31:0] drd_din,
   output logic        m_vout,
   output logic [31:0] m_dout,
   input  logic        m_vin,
   input  logic [31:0] m_din,
   output logic [1:0]  grant_id,
   output logic        busy,
   output logic        timeout,
   input  logic        clr_timeout
);

   // Terminal values of the watchdog and drain counters.
   localparam logic [15:0] WDOG_LAST  = 16'(MAX_GRANT - 1);
   localparam logic [3:0]  DRAIN_LAST = 4'(DRAIN_CYC - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [1:0]  last;
   logic [15:0] wdog;
   logic [3:0]  dcnt;

   logic        owner_req;
   logic        owner_vout;
   logic [31:0] owner_dout;
   logic [1:0]  pick;
   logic        take;
   logic        rel_now;
   logic        forced;
   logic        route;

   // One-hot decode of a requester index (index 3 never occurs).
   function automatic logic [2:0] onehot3(input logic [1:0] idx);
      logic [2:0] oh;
      oh = 3'b000;
      case (idx)
         2'd0:    oh = 3'b001;
         2'd1:    oh = 3'b010;
         2'd2:    oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

   // Select the owner's request, command valid and command word.
   always_comb begin
      owner_req  = drd_req[0];
      owner_vout = drd_vout[0];
      owner_dout = drd_dout[31:0];
      case (grant_id)
         2'd1: begin
            owner_req  = drd_req[1];
            owner_vout = drd_vout[1];
            owner_dout = drd_dout[63:32];
         end
         2'd2: begin
            owner_req  = drd_req[2];
            owner_vout = drd_vout[2];
            owner_dout = drd_dout[95:64];
         end
         default: begin
            owner_req  = drd_req[0];
            owner_vout = drd_vout[0];
            owner_dout = drd_dout[31:0];
         end
      endcase
   end

   // Round-robin choice: scan last+1, last+2, last+3 (mod 3); the
   // previous owner is considered only when nobody else is asking.
   always_comb begin
      pick = 2'd0;
      case (last)
         2'd0:    pick = drd_req[1] ? 2'd1 : (drd_req[2] ? 2'd2 : 2'd0);
         2'd1:    pick = drd_req[2] ? 2'd2 : (drd_req[0] ? 2'd0 : 2'd1);
         default: pick = drd_req[0] ? 2'd0 : (drd_req[1] ? 2'd1 : 2'd2);
      endcase
   end

   // Next-state logic and the per-cycle control strobes.
   always_comb begin
      state_nx = state;
      take     = 1'b0;
      rel_now  = 1'b0;
      forced   = 1'b0;
      route    = 1'b0;
      case (state)
         IDLE: begin
            if (|drd_req) begin
               state_nx = GRANT;
               take     = 1'b1;
            end
         end
         GRANT: begin
            route = 1'b1;
            if (!owner_req) begin
               state_nx = DRAIN;
               rel_now  = 1'b1;
            end else if (wdog == WDOG_LAST) begin
               state_nx = DRAIN;
               rel_now  = 1'b1;
               forced   = 1'b1;
            end
         end
         DRAIN: begin
            route = 1'b1;
            if (dcnt == DRAIN_LAST) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Grant bookkeeping: ack, owner index, busy and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drd_ack  <= 3'b000;
         grant_id <= 2'd0;
         last     <= 2'd2;
         busy     <= 1'b0;
      end else begin
         busy <= (state_nx != IDLE);
         if (take) begin
            drd_ack  <= onehot3(pick);
            grant_id <= pick;
         end else if (rel_now) begin
            drd_ack <= 3'b000;
            last    <= grant_id;
         end
      end
   end

   // Watchdog counts GRANT cycles and saturates rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog <= 16'd0;
      end else if (take) begin
         wdog <= 16'd0;
      end else if ((state == GRANT) && (wdog != 16'hFFFF)) begin
         wdog <= wdog + 16'd1;
      end
   end

   // Drain counter counts DRAIN cycles and saturates rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dcnt <= 4'd0;
      end else if (rel_now) begin
         dcnt <= 4'd0;
      end else if ((state == DRAIN) && (dcnt != 4'hF)) begin
         dcnt <= dcnt + 4'd1;
      end
   end

   // Command path: the owner's words are registered toward the read
   // master; nothing is issued on the release cycle or outside GRANT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_vout <= 1'b0;
         m_dout <= 32'd0;
      end else if ((state == GRANT) && !rel_now) begin
         m_vout <= owner_vout;
         m_dout <= owner_dout;
      end else begin
         m_vout <= 1'b0;
      end
   end

   // Return path: read data reaches only the current or draining owner;
   // anything arriving while idle is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drd_vin <= 3'b000;
         drd_din <= 32'd0;
      end else if (route) begin
         drd_vin <= m_vin ? onehot3(grant_id) : 3'b000;
         drd_din <= m_din;
      end else begin
         drd_vin <= 3'b000;
      end
   end

   // Sticky timeout flag; a new forced release beats a clear request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timeout <= 1'b0;
      end else if (forced) begin
         timeout <= 1'b1;
      end else if (clr_timeout) begin
         timeout <= 1'b0;
      end
   end

endmodule
